// File: rtl/mem_test_gen_if.sv
// Burst request/data bus between mem_test_gen (master side) and the AXI burst master (slave side).
interface mem_test_gen_if #(
  parameter int MEM_DATA_BITS = 64
);
  logic                     wr_burst_req;
  logic [9:0]               wr_burst_len;
  logic [31:0]              wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;
  logic                     rd_burst_req;
  logic [9:0]               rd_burst_len;
  logic [31:0]              rd_burst_addr;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );
endinterface

// File: rtl/mem_test_gen.sv
// Write-then-readback memory sweeper with pattern select, error counting and first-failure capture.
// Define MEM_TEST_PRBS_EN to build the LFSR pattern for mode 3; otherwise mode 3 repeats mode 0.
module mem_test_gen #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 27,
  parameter int BURST_LEN     = 128,
  parameter int CNT_BITS      = 16
) (
  input  logic                 mem_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  mem_test_gen_if.master       bus,
  output logic                 busy,
  output logic                 error,
  output logic [CNT_BITS-1:0]  err_cnt,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic [CNT_BITS-1:0]  pass_cnt
);
  localparam int                   LANES     = MEM_DATA_BITS / 32;
  localparam int                   IDX_BITS  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_BITS-1:0]  IDX_MASK  = IDX_BITS'(BURST_LEN - 1);
  localparam logic [ADDR_BITS-1:0] LAST_BASE = ~ADDR_BITS'(BURST_LEN - 1);
  localparam logic [31:0]          DW        = 32'(MEM_DATA_BITS);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP} state_e;
  typedef logic [MEM_DATA_BITS-1:0] word_t;

  function automatic word_t pattern(input logic [1:0] md, input logic [ADDR_BITS-1:0] a);
    word_t lanes;
    lanes = {LANES{32'(a)}};
    unique case (md)
      2'd1:    return ~lanes;
      2'd2:    return word_t'(1) << (32'(a) % DW);
      default: return lanes;
    endcase
  endfunction

`ifdef MEM_TEST_PRBS_EN
  // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting toward the MSB.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [ADDR_BITS-1:0] b);
    logic [31:0] s;
    s = 32'(b) ^ 32'hA5A5_A5A5;
    return (s == '0) ? 32'h1 : s;
  endfunction

  logic [31:0] wr_lfsr_q, wr_lfsr_d, rd_lfsr_q, rd_lfsr_d;
`endif

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [IDX_BITS-1:0]  wi_q, wi_d, ri_q, ri_d;
  word_t                wr_data_q, wr_data_d;
  logic                 wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic                 busy_q, busy_d, error_q, error_d;
  logic [CNT_BITS-1:0]  err_cnt_q, err_cnt_d, pass_cnt_q, pass_cnt_d;
  logic [ADDR_BITS-1:0] first_err_addr_q, first_err_addr_d;
  logic                 first_err_seen_q, first_err_seen_d;
  logic [ADDR_BITS-1:0] wr_word_addr, rd_word_addr;
  word_t                expect_word;
  logic                 wr_beat, rd_beat, mismatch;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d          = state_q;
    mode_d           = mode_q;
    base_d           = base_q;
    wi_d             = wi_q;
    ri_d             = ri_q;
    wr_data_d        = wr_data_q;
    pass_cnt_d       = pass_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    first_err_seen_d = first_err_seen_q;
    wr_beat          = (state_q == WR_REQ) && bus.wr_burst_data_req;
    rd_beat          = (state_q == RD_REQ) && bus.rd_burst_data_valid;
`ifdef MEM_TEST_PRBS_EN
    wr_lfsr_d        = wr_lfsr_q;
    rd_lfsr_d        = rd_lfsr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          mode_d  = mode;
          base_d  = '0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (wr_beat) wi_d = (wi_q + IDX_BITS'(1)) & IDX_MASK;
        if (bus.wr_burst_finish) state_d = WR_GAP;
      end
      WR_GAP: state_d = RD_REQ;
      RD_REQ: if (bus.rd_burst_finish) state_d = RD_GAP;
      RD_GAP: begin
        if (base_q == LAST_BASE) begin
          base_d     = '0;
          pass_cnt_d = pass_cnt_q + CNT_BITS'(1);
          if (enable) mode_d = mode;
        end else begin
          base_d = base_q + ADDR_BITS'(BURST_LEN);
        end
        state_d = enable ? WR_REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WR_REQ && state_q != WR_REQ) wi_d = '0;
    if (state_d == RD_REQ && state_q != RD_REQ) ri_d = '0;
    if (rd_beat) ri_d = (ri_q + IDX_BITS'(1)) & IDX_MASK;

    // Write word for the next cycle is prepared now so back-to-back data requests run at full rate.
    wr_word_addr = base_d + ADDR_BITS'(wi_d);
    if (state_d == WR_REQ) begin
      wr_data_d = pattern(mode_d, wr_word_addr);
`ifdef MEM_TEST_PRBS_EN
      if (wi_d == '0)   wr_lfsr_d = lfsr_seed(base_d);
      else if (wr_beat) wr_lfsr_d = lfsr_step(wr_lfsr_q);
      if (mode_d == 2'd3) wr_data_d = {LANES{wr_lfsr_d}};
`endif
    end

    rd_word_addr = base_q + ADDR_BITS'(ri_q);
    expect_word  = pattern(mode_q, rd_word_addr);
`ifdef MEM_TEST_PRBS_EN
    if (mode_q == 2'd3) expect_word = {LANES{rd_lfsr_q}};
    if (state_d == RD_REQ && state_q != RD_REQ) rd_lfsr_d = lfsr_seed(base_q);
    else if (rd_beat) rd_lfsr_d = (ri_d == '0) ? lfsr_seed(base_q) : lfsr_step(rd_lfsr_q);
`endif

    mismatch = rd_beat && (bus.rd_burst_data != expect_word);
    error_d  = mismatch;
    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_BITS'(1);
      if (!first_err_seen_q) begin
        first_err_seen_d = 1'b1;
        first_err_addr_d = rd_word_addr;
      end
    end

    wr_req_d = (state_d == WR_REQ);
    rd_req_d = (state_d == RD_REQ);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      mode_q           <= '0;
      base_q           <= '0;
      wi_q             <= '0;
      ri_q             <= '0;
      wr_data_q        <= '0;
      wr_req_q         <= 1'b0;
      rd_req_q         <= 1'b0;
      busy_q           <= 1'b0;
      error_q          <= 1'b0;
      err_cnt_q        <= '0;
      pass_cnt_q       <= '0;
      first_err_addr_q <= '0;
      first_err_seen_q <= 1'b0;
`ifdef MEM_TEST_PRBS_EN
      wr_lfsr_q        <= '0;
      rd_lfsr_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q          <= state_d;
      mode_q           <= mode_d;
      base_q           <= base_d;
      wi_q             <= wi_d;
      ri_q             <= ri_d;
      wr_data_q        <= wr_data_d;
      wr_req_q         <= wr_req_d;
      rd_req_q         <= rd_req_d;
      busy_q           <= busy_d;
      error_q          <= error_d;
      err_cnt_q        <= err_cnt_d;
      pass_cnt_q       <= pass_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_seen_q <= first_err_seen_d;
`ifdef MEM_TEST_PRBS_EN
      wr_lfsr_q        <= wr_lfsr_d;
      rd_lfsr_q        <= rd_lfsr_d;
`endif
    end
  end

  assign bus.wr_burst_req  = wr_req_q;
  assign bus.wr_burst_len  = 10'(BURST_LEN);
  assign bus.wr_burst_addr = 32'(base_q);
  assign bus.wr_burst_data = wr_data_q;
  assign bus.rd_burst_req  = rd_req_q;
  assign bus.rd_burst_len  = 10'(BURST_LEN);
  assign bus.rd_burst_addr = 32'(base_q);
  assign busy              = busy_q;
  assign error             = error_q;
  assign err_cnt           = err_cnt_q;
  assign first_err_addr    = first_err_addr_q;
  assign pass_cnt          = pass_cnt_q;
endmodule

// File: tb/tb_mem_test_gen.sv
// Directed bench for mem_test_gen: 1K-word window, 128-word bursts, 4-bit counters, in-bench memory model.
module tb_mem_test_gen;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BL = 128;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable;
  logic [1:0]    mode;
  logic          busy;
  logic          error;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] pass_cnt;
  logic [AW-1:0] first_err_addr;

  mem_test_gen_if #(.MEM_DATA_BITS(DW)) bus ();

  mem_test_gen #(
    .MEM_DATA_BITS(DW),
    .ADDR_BITS    (AW),
    .BURST_LEN    (BL),
    .CNT_BITS     (CW)
  ) dut (
    .mem_clk       (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mode          (mode),
    .bus           (bus.master),
    .busy          (busy),
    .error         (error),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr),
    .pass_cnt      (pass_cnt)
  );

  logic [DW-1:0] mem [1024];
  int vectors     = 0;
  int miscompares = 0;
  int rd_err_pulses;
  int rd_err_word;
  int idle_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int md, input int a);
    logic [31:0] w;
    w = a;
    case (md)
      1:       return ~{w, w};
      2:       return 64'd1 << (a % 64);
      default: return {w, w};
    endcase
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_wr_req"},  bus.wr_burst_req, 0);
    check({tag, "_rd_req"},  bus.rd_burst_req, 0);
    check({tag, "_error"},   error, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_ferr"},    first_err_addr, 0);
    check({tag, "_pass"},    pass_cnt, 0);
    check({tag, "_wr_addr"}, bus.wr_burst_addr, 0);
    check({tag, "_rd_addr"}, bus.rd_burst_addr, 0);
    check({tag, "_wr_data"}, bus.wr_burst_data, 0);
  endtask

  // Serves one write burst at full rate; enters and leaves on a falling edge.
  task automatic do_write(input int exp_base, input int md, input bit chk_words, input bit drop_en);
    int t = 0;
    while (bus.wr_burst_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("wr_req_seen", bus.wr_burst_req, 1);
    if (bus.wr_burst_req !== 1'b1) return;
    check("wr_addr", bus.wr_burst_addr, exp_base);
    for (int i = 0; i < BL; i++) begin
      if (chk_words) check("wr_data", bus.wr_burst_data, pat(md, exp_base + i));
      mem[exp_base + i] = bus.wr_burst_data;
      if (drop_en && i == 10) enable = 1'b0;
      bus.wr_burst_data_req = 1'b1;
      @(negedge clk);
    end
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b1;
    @(negedge clk);
    bus.wr_burst_finish = 1'b0;
    check("wr_req_drop", bus.wr_burst_req, 0);
    check("rd_req_gap", bus.rd_burst_req, 0);
    @(negedge clk);
    check("rd_req_rise", bus.rd_burst_req, 1);
  endtask

  // Returns stored words (optionally one corrupted, or all zero) and logs error pulses by beat.
  task automatic do_read(input int exp_base, input int corrupt, input bit stuck);
    int t = 0;
    logic [DW-1:0] d;
    rd_err_pulses = 0;
    rd_err_word   = -1;
    while (bus.rd_burst_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rd_req_seen", bus.rd_burst_req, 1);
    if (bus.rd_burst_req !== 1'b1) return;
    check("rd_addr", bus.rd_burst_addr, exp_base);
    for (int i = 0; i < BL; i++) begin
      d = stuck ? '0 : mem[exp_base + i];
      if (exp_base + i == corrupt) d[5] = ~d[5];
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = d;
      @(negedge clk);
      if (error === 1'b1) begin
        rd_err_pulses++;
        if (rd_err_word < 0) rd_err_word = exp_base + i;
      end
    end
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_finish     = 1'b1;
    @(negedge clk);
    bus.rd_burst_finish = 1'b0;
    if (error === 1'b1) rd_err_pulses++;
    check("rd_req_drop", bus.rd_burst_req, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    mode = 2'd0;
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_finish     = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("wr_len", bus.wr_burst_len, BL);
    check("rd_len", bus.rd_burst_len, BL);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", bus.wr_burst_req, 0);

    // Sweep 1, mode 0; the mode input changes mid-sweep but must not take effect until the wrap.
    enable = 1'b1;
    @(negedge clk);
    check("start_wr_req", bus.wr_burst_req, 1);
    for (int k = 0; k < 8; k++) begin
      do_write(k * BL, 0, 1'b1, 1'b0);
      if (k == 0) mode = 2'd1;
      do_read(k * BL, -1, 1'b0);
      check("sweep1_err_pulses", rd_err_pulses, 0);
    end
    check("pass_before_wrap", pass_cnt, 0);
    @(negedge clk);
    check("pass_after_wrap", pass_cnt, 1);
    check("wrap_wr_addr", bus.wr_burst_addr, 0);
    check("sweep1_err_cnt", err_cnt, 0);

    // Sweep 2, mode 1: corrupt bit 5 of word 0x105 and drop enable during the third write.
    do_write(0, 1, 1'b1, 1'b0);
    do_read(0, -1, 1'b0);
    do_write(BL, 1, 1'b1, 1'b0);
    do_read(BL, -1, 1'b0);
    do_write(2 * BL, 1, 1'b1, 1'b1);
    do_read(2 * BL, 'h105, 1'b0);
    check("corrupt_pulses", rd_err_pulses, 1);
    check("corrupt_beat", rd_err_word, 'h105);
    check("corrupt_err_cnt", err_cnt, 1);
    check("corrupt_first_addr", first_err_addr, 'h105);
    check("rd_gap_busy", busy, 1);
    @(negedge clk);
    check("stop_busy", busy, 0);

    // Idle: stray valid beats and finish pulses must be ignored, and no new burst starts.
    idle_bad = 0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = 64'hDEAD_BEEF_0BAD_F00D;
      bus.rd_burst_finish     = i[0];
      bus.wr_burst_finish     = ~i[0];
      @(negedge clk);
      if (error !== 1'b0 || bus.wr_burst_req !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_finish     = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    check("idle_ignored", idle_bad, 0);
    check("idle_err_cnt", err_cnt, 1);

    // Reset asserted in the middle of a read burst.
    mode = 2'd0;
    enable = 1'b1;
    @(negedge clk);
    do_write(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = mem[i];
      @(negedge clk);
    end
    bus.rd_burst_data_valid = 1'b0;
    check("pre_reset_rd_req", bus.rd_burst_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrd_reset");
    mode = 2'd1;
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_wr_req", bus.wr_burst_req, 1);
    check("restart_wr_addr", bus.wr_burst_addr, 0);

    // Stuck-at-zero memory with mode 1: every beat mismatches and the 4-bit count saturates.
    do_write(0, 1, 1'b1, 1'b0);
    enable = 1'b0;
    do_read(0, -1, 1'b1);
    check("stuck_pulses", rd_err_pulses, BL);
    check("stuck_err_cnt", err_cnt, 15);
    check("stuck_first_addr", first_err_addr, 0);
    @(negedge clk);
    check("stuck_stop_busy", busy, 0);

    // Mode 3: PRBS when built with the LFSR, otherwise identical to mode 0.
    mode = 2'd3;
    enable = 1'b1;
    @(negedge clk);
    check("m3_wr_req", bus.wr_burst_req, 1);
`ifdef MEM_TEST_PRBS_EN
    check("m3_first_word", bus.wr_burst_data, {2{32'hA5A5_A5A5}});
    do_write(0, 3, 1'b0, 1'b1);
`else
    check("m3_first_word", bus.wr_burst_data, pat(0, 0));
    do_write(0, 0, 1'b1, 1'b1);
`endif
    do_read(0, -1, 1'b0);
    check("m3_err_pulses", rd_err_pulses, 0);
    check("m3_err_cnt_held", err_cnt, 15);
    @(negedge clk);
    check("m3_stop_busy", busy, 0);

    // Mode 2: walking one.
    mode = 2'd2;
    enable = 1'b1;
    @(negedge clk);
    do_write(0, 2, 1'b1, 1'b1);
    do_read(0, -1, 1'b0);
    check("m2_err_pulses", rd_err_pulses, 0);
    @(negedge clk);
    check("m2_stop_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
